// File: rtl/sam_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
package sam_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        BUSY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam int unsigned AW_DEF      = 16;
    localparam int unsigned DW_DEF      = 16;
    localparam int unsigned TIMEOUT_DEF = 255;

    localparam logic RW_READ  = 1'b1;
    localparam logic RW_WRITE = 1'b0;

endpackage

// File: rtl/arb_pick.sv
// Combinational winner select between two requesters; pref breaks ties.
module arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic pref,
    output logic grant
);

    always_comb begin
        grant = 1'b0;
        if (req0 && req1) begin
            grant = pref;
        end else if (req1) begin
            grant = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port memory arbiter: IDLE -> ISSUE -> BUSY -> DONE, registered outputs.
// Define MEM_ARB_RR_EN for round-robin arbitration; default is port 0 fixed priority.
module mem_arbiter
    import sam_pkg::*;
#(
    parameter int unsigned AW      = AW_DEF,
    parameter int unsigned DW      = DW_DEF,
    parameter int unsigned TIMEOUT = TIMEOUT_DEF
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          req0,
    input  logic          req1,
    input  logic          rw0,
    input  logic          rw1,
    input  logic [AW-1:0] addr0,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata0,
    input  logic [DW-1:0] wdata1,
    output logic          ack0,
    output logic          ack1,
    output logic [DW-1:0] rdata,
    output logic          err,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    output logic          mem_req,
    output logic          mem_rw,
    input  logic          mem_wait,
    input  logic [DW-1:0] mem_rdata
);

    // Counter value seen on the last tolerated busy cycle.
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t     state;
    logic [7:0] cnt;
    logic       owner;
    logic       grant;
    logic       pref;

    arb_pick u_arb_pick (
        .req0  (req0),
        .req1  (req1),
        .pref  (pref),
        .grant (grant)
    );

`ifdef MEM_ARB_RR_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            pref <= 1'b0;
        end else if (state == IDLE && (req0 || req1)) begin
            pref <= ~grant;
        end
    end
`else
    assign pref = 1'b0;
`endif

    // The mem_* registers double as the latched request; they are only
    // loaded in IDLE, so requester changes mid-transaction are ignored.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            owner     <= 1'b0;
            rdata     <= '0;
            mem_req   <= 1'b0;
            mem_rw    <= RW_READ;
            mem_addr  <= '0;
            mem_wdata <= '0;
            ack0      <= 1'b0;
            ack1      <= 1'b0;
            err       <= 1'b0;
        end else begin
            ack0 <= 1'b0;
            ack1 <= 1'b0;
            err  <= 1'b0;
            case (state)
                IDLE: begin
                    if (req0 || req1) begin
                        owner     <= grant;
                        mem_rw    <= grant ? rw1 : rw0;
                        mem_addr  <= grant ? addr1 : addr0;
                        mem_wdata <= grant ? wdata1 : wdata0;
                        mem_req   <= 1'b1;
                        cnt       <= '0;
                        state     <= ISSUE;
                    end
                end
                ISSUE: state <= BUSY;
                BUSY: begin
                    if (!mem_wait) begin
                        if (mem_rw == RW_READ) begin
                            rdata <= mem_rdata;
                        end
                        mem_req <= 1'b0;
                        ack0    <= ~owner;
                        ack1    <= owner;
                        state   <= DONE;
                    end else if (cnt == CNT_LAST) begin
                        mem_req <= 1'b0;
                        ack0    <= ~owner;
                        ack1    <= owner;
                        err     <= 1'b1;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + 8'd1;
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter (TIMEOUT=8); expectations follow MEM_ARB_RR_EN.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, rw0, rw1;
    logic [15:0] addr0, addr1, wdata0, wdata1;
    logic        ack0, ack1, err;
    logic [15:0] rdata;
    logic [15:0] mem_addr, mem_wdata, mem_rdata;
    logic        mem_req, mem_rw, mem_wait;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mem_arbiter #(
        .AW      (16),
        .DW      (16),
        .TIMEOUT (8)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req0      (req0),
        .req1      (req1),
        .rw0       (rw0),
        .rw1       (rw1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .ack0      (ack0),
        .ack1      (ack1),
        .rdata     (rdata),
        .err       (err),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_req   (mem_req),
        .mem_rw    (mem_rw),
        .mem_wait  (mem_wait),
        .mem_rdata (mem_rdata)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    int  exp_id;
    int  id;
    bit  seen;

    initial begin
        reset = 1'b1;
        req0 = 1'b0; req1 = 1'b0; rw0 = 1'b1; rw1 = 1'b1;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        mem_wait = 1'b0; mem_rdata = '0;
        tick();
        tick();
        reset = 1'b0;

        check("rst_mem_req", mem_req, 0);
        check("rst_mem_rw", mem_rw, 1);
        check("rst_mem_addr", mem_addr, 0);
        check("rst_mem_wdata", mem_wdata, 0);
        check("rst_acks_err", {ack0, ack1, err}, 0);
        check("rst_rdata", rdata, 0);

        // Single read, no wait: ISSUE, BUSY, then ack in cycle 3.
        req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0010; mem_rdata = 16'hBEEF;
        tick();
        check("rd_c1_req", mem_req, 1);
        check("rd_c1_addr", mem_addr, 16'h0010);
        check("rd_c1_rw", mem_rw, 1);
        check("rd_c1_ack", {ack0, ack1}, 0);
        tick();
        check("rd_c2_req", mem_req, 1);
        check("rd_c2_ack", {ack0, ack1}, 0);
        tick();
        check("rd_c3_ack0", ack0, 1);
        check("rd_c3_ack1", ack1, 0);
        check("rd_c3_err", err, 0);
        check("rd_c3_req", mem_req, 0);
        check("rd_c3_rdata", rdata, 16'hBEEF);
        req0 = 1'b0;
        tick();
        check("rd_idle_ack0", ack0, 0);

        // Write held in BUSY by 4 wait cycles; ack in cycle 7.
        req1 = 1'b1; rw1 = 1'b0; addr1 = 16'h0020; wdata1 = 16'h1234;
        mem_wait = 1'b1; mem_rdata = 16'hDEAD;
        tick();
        check("wr_c1_addr", mem_addr, 16'h0020);
        for (int c = 2; c <= 6; c++) begin
            if (c == 3) wdata1 = 16'hFFFF;
            tick();
            check($sformatf("wr_c%0d_req", c), mem_req, 1);
            check($sformatf("wr_c%0d_wdata", c), mem_wdata, 16'h1234);
            check($sformatf("wr_c%0d_rw", c), mem_rw, 0);
            check($sformatf("wr_c%0d_ack", c), {ack0, ack1}, 0);
        end
        mem_wait = 1'b0;
        tick();
        check("wr_c7_ack1", ack1, 1);
        check("wr_c7_ack0", ack0, 0);
        check("wr_c7_err", err, 0);
        check("wr_c7_rdata", rdata, 16'hBEEF);
        req1 = 1'b0;
        tick();

        // Contention: both held high across 4 back-to-back transactions.
        req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0100;
        req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0200;
        mem_rdata = 16'h5555;
        for (int t = 0; t < 4; t++) begin
`ifdef MEM_ARB_RR_EN
            exp_id = t % 2;
`else
            exp_id = 0;
`endif
            seen = 1'b0;
            id = -1;
            for (int c = 0; c < 8 && !seen; c++) begin
                tick();
                if (ack0 || ack1) begin
                    seen = 1'b1;
                    id = ack1 ? 1 : 0;
                end
            end
            check($sformatf("cont%0d_ack_seen", t), seen, 1);
            check($sformatf("cont%0d_owner", t), id, exp_id);
            check($sformatf("cont%0d_one_ack", t), ack0 & ack1, 0);
        end
        check("cont_rdata", rdata, 16'h5555);
        req0 = 1'b0; req1 = 1'b0;
        tick();
        tick();
        check("cont_idle_req", mem_req, 0);

        // Timeout: wait stuck high, abort after 8 BUSY cycles.
        req0 = 1'b1; rw0 = 1'b1; addr0 = 16'h0030; mem_wait = 1'b1; mem_rdata = 16'hAAAA;
        tick();
        for (int c = 2; c <= 9; c++) begin
            tick();
            check($sformatf("to_c%0d_req", c), mem_req, 1);
            check($sformatf("to_c%0d_ack_err", c), {ack0, err}, 0);
        end
        tick();
        check("to_ack0", ack0, 1);
        check("to_err", err, 1);
        check("to_req", mem_req, 0);
        check("to_rdata", rdata, 16'h5555);
        req0 = 1'b0; mem_wait = 1'b0;
        tick();
        check("to_idle_ack_err", {ack0, err}, 0);
        check("to_idle_req", mem_req, 0);

        // Reset while BUSY aborts silently.
        req1 = 1'b1; rw1 = 1'b1; addr1 = 16'h0040; mem_wait = 1'b1;
        tick();
        tick();
        check("rb_busy_req", mem_req, 1);
        reset = 1'b1; req1 = 1'b0;
        tick();
        reset = 1'b0;
        check("rb_req", mem_req, 0);
        check("rb_ack_err", {ack0, ack1, err}, 0);
        check("rb_rw", mem_rw, 1);
        check("rb_addr", mem_addr, 0);
        check("rb_rdata", rdata, 0);
        tick();
        check("rb_idle_req", mem_req, 0);
        check("rb_idle_ack_err", {ack0, ack1, err}, 0);

        // After reset port 0 is preferred in either arbitration mode.
        req0 = 1'b1; req1 = 1'b1; rw0 = 1'b1; addr0 = 16'h0050;
        mem_wait = 1'b0; mem_rdata = 16'h0C0C;
        tick();
        check("post_addr", mem_addr, 16'h0050);
        tick();
        tick();
        check("post_ack0", ack0, 1);
        check("post_ack1", ack1, 0);
        check("post_rdata", rdata, 16'h0C0C);
        req0 = 1'b0; req1 = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
